// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator with a shared prescaler and period counter.
// Duty values are double-buffered: writes land in a shadow register and are
// copied to the active compare register only when the period wraps.
module pwm_multichannel #(
  parameter int unsigned NUM_CH  = 16,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PRESC_W = 8
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_CH-1:0]                            en_out,
  input  logic [NUM_CH-1:0]                            en_pwm,
  input  logic [PRESC_W-1:0]                           prescale,
  input  logic [CNT_W-1:0]                             period,
  input  logic                                         duty_wr,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] duty_sel,
  input  logic [CNT_W-1:0]                             duty_data,
  output logic [NUM_CH-1:0]                            out,
  output logic                                         period_tick
);

  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Channel count widened by one bit so the range check also works for powers of two.
  localparam logic [SEL_W:0] NumChW = (SEL_W + 1)'(NUM_CH);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   shadow_q [NUM_CH];
  logic [CNT_W-1:0]   shadow_d [NUM_CH];
  logic [CNT_W-1:0]   active_q [NUM_CH];
  logic [CNT_W-1:0]   active_d [NUM_CH];
  logic [NUM_CH-1:0]  out_q, out_d;
  logic               tick_q, tick_d;

  logic               step;
  logic               wrap;
  logic               wr_ok;
  logic [NUM_CH-1:0]  hit;

  // Prescaler and period counter next state.
  always_comb begin
    step    = (presc_q == prescale);
    presc_d = step ? '0 : presc_q + PRESC_W'(1);
    wrap    = step && (cnt_q == period);
    cnt_d   = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (step) begin
      // Counts past a lowered period roll over through the full range.
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d = wrap;
  end

  // Duty shadow writes, wrap-time apply with same-cycle forwarding, and outputs.
  always_comb begin
    wr_ok = duty_wr && ({1'b0, duty_sel} < NumChW);
    hit   = '0;
    out_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i]      = wr_ok && (duty_sel == SEL_W'(i));
      shadow_d[i] = hit[i] ? duty_data : shadow_q[i];
      active_d[i] = active_q[i];
      if (wrap) begin
        active_d[i] = hit[i] ? duty_data : shadow_q[i];
      end
      out_d[i] = en_out[i] & (~en_pwm[i] | (cnt_q < active_q[i]));
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      tick_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign out         = out_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel (4 channels). The reference model
// derives the counter position and wrap instants directly from elapsed clocks
// since reset: cnt = (t / (prescale+1)) mod (period+1).
module tb_pwm_multichannel;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en_out, en_pwm;
  logic [7:0]     prescale, period;
  logic           duty_wr;
  logic [1:0]     duty_sel;
  logic [7:0]     duty_data;
  logic [NCH-1:0] out;
  logic           period_tick;

  always #5 clk = ~clk;

  pwm_multichannel #(
    .NUM_CH (NCH),
    .CNT_W  (8),
    .PRESC_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_out     (en_out),
    .en_pwm     (en_pwm),
    .prescale   (prescale),
    .period     (period),
    .duty_wr    (duty_wr),
    .duty_sel   (duty_sel),
    .duty_data  (duty_data),
    .out        (out),
    .period_tick(period_tick)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int t;
  int shadow_m[NCH];
  int active_m[NCH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cnt_m();
    return (t / (int'(prescale) + 1)) % (int'(period) + 1);
  endfunction

  function automatic bit wrap_next();
    int l;
    l = (int'(prescale) + 1) * (int'(period) + 1);
    return (t % l) == (l - 1);
  endfunction

  // One clock: predict, advance model, compare after the edge.
  task automatic cycle();
    logic [NCH-1:0] exp_out;
    bit             w;
    int             c;
    c = cnt_m();
    w = wrap_next();
    for (int i = 0; i < NCH; i++) begin
      exp_out[i] = en_out[i] && (!en_pwm[i] || (c < active_m[i]));
    end
    @(posedge clk);
    if (!rst_n) begin
      t       = 0;
      exp_out = '0;
      w       = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        shadow_m[i] = 0;
        active_m[i] = 0;
      end
    end else begin
      if (w) begin
        for (int i = 0; i < NCH; i++) begin
          active_m[i] = (duty_wr && int'(duty_sel) == i) ? int'(duty_data) : shadow_m[i];
        end
      end
      if (duty_wr) shadow_m[int'(duty_sel)] = int'(duty_data);
      t++;
    end
    #1;
    check_eq("out", {28'd0, out}, {28'd0, exp_out});
    check_eq("tick", {31'd0, period_tick}, {31'd0, w});
    duty_wr = 1'b0;
  endtask

  task automatic run(input int n, output int hi[NCH], output int ticks);
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    ticks = 0;
    for (int k = 0; k < n; k++) begin
      cycle();
      for (int i = 0; i < NCH; i++) hi[i] += int'(out[i]);
      ticks += int'(period_tick);
    end
  endtask

  task automatic wr(input int ch, input int val);
    duty_wr   = 1'b1;
    duty_sel  = 2'(ch);
    duty_data = 8'(val);
    cycle();
  endtask

  task automatic do_reset(input int pr, input int pe);
    prescale = 8'(pr);
    period   = 8'(pe);
    rst_n    = 1'b0;
    cycle();
    rst_n    = 1'b1;
  endtask

  int hi[NCH];
  int ticks;

  initial begin
    rst_n = 1'b0; en_out = '0; en_pwm = '0; prescale = '0; period = '0;
    duty_wr = 1'b0; duty_sel = '0; duty_data = '0;
    t = 0;
    for (int i = 0; i < NCH; i++) begin
      shadow_m[i] = 0;
      active_m[i] = 0;
    end

    // Reset state.
    do_reset(0, 9);
    check_eq("rst_out", {28'd0, out}, 32'd0);
    check_eq("rst_tick", {31'd0, period_tick}, 32'd0);

    // Tests 1-3: duty 3 on ch0, static ch1, disabled ch2, 100% ch3.
    en_out = 4'b1011;
    en_pwm = 4'b1101;
    wr(0, 3); wr(2, 5); wr(3, 10);
    run(20, hi, ticks);
    run(10, hi, ticks);
    check_eq("t1_hi0", hi[0], 3);
    check_eq("t1_ticks", ticks, 1);
    check_eq("t2_static1", hi[1], 10);
    check_eq("t2_off2", hi[2], 0);
    check_eq("t3_full3", hi[3], 10);
    wr(0, 0); wr(3, 255);
    run(12, hi, ticks);
    run(20, hi, ticks);
    check_eq("t3_zero0", hi[0], 0);
    check_eq("t3_max3", hi[3], 20);

    // Test 4: prescaled period of 20 clocks, 8 high.
    do_reset(3, 4);
    en_out = 4'hF; en_pwm = 4'hF;
    wr(0, 2);
    run(40, hi, ticks);
    run(20, hi, ticks);
    check_eq("t4_hi0", hi[0], 8);
    check_eq("t4_ticks", ticks, 1);

    // Test 5: mid-period update, then write landing exactly on the wrap.
    do_reset(0, 9);
    wr(0, 3);
    run(12, hi, ticks);
    while (cnt_m() != 5) cycle();
    wr(0, 7);
    run(25, hi, ticks);
    while (!wrap_next()) cycle();
    wr(0, 2);
    run(10, hi, ticks);
    check_eq("t5_wrapwr", hi[0], 2);

    // Test 6: reset mid-pulse clears everything until duties are rewritten.
    while (cnt_m() != 1) cycle();
    do_reset(0, 9);
    check_eq("t6_out", {28'd0, out}, 32'd0);
    check_eq("t6_tick", {31'd0, period_tick}, 32'd0);
    run(30, hi, ticks);
    check_eq("t6_low0", hi[0], 0);
    wr(0, 4);
    run(20, hi, ticks);

    // Randomised segments.
    for (int s = 0; s < 10; s++) begin
      do_reset($urandom_range(0, 3), (s == 9) ? 255 : $urandom_range(0, 30));
      en_out = 4'($urandom);
      en_pwm = 4'($urandom);
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          duty_wr   = 1'b1;
          duty_sel  = 2'($urandom);
          duty_data = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 32));
        end
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
